// File: rtl/bf16_to_dec_pkg.sv
// Shared definitions for the BF16-to-decimal display stage: BF16 field layout,
// well-known BF16 constants, the BCD blank code, default sizes and FSM/result encodings.
package bf16_to_dec_pkg;

  localparam int DEF_DIGITS = 8;
  localparam int DEF_BIN_W  = 27;

  localparam int BF16_SIGN_BIT = 15;
  localparam int BF16_EXP_LSB  = 7;
  localparam int BF16_EXP_W    = 8;
  localparam int BF16_FRAC_W   = 7;
  localparam int BF16_BIAS     = 127;

  localparam logic [15:0] BF16_ONE = 16'h3F80;
  localparam logic [15:0] BF16_NAN = 16'hFFC0;
  localparam logic [15:0] BF16_INF = 16'h7F80;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNPACK  = 3'd1,
    S_ALIGN   = 3'd2,
    S_RANGE   = 3'd3,
    S_CONVERT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_NORM = 2'd0,
    RES_OVF  = 2'd1,
    RES_ERR  = 2'd2
  } res_t;

endpackage

// File: rtl/bf16_to_dec_bin_to_bcd_seq.sv
// Sequential double-dabble core: one add-3/shift iteration per cycle, BIN_W
// iterations after load. done is high during the final iteration cycle.
module bin_to_bcd_seq
  import bf16_to_dec_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int SW = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIN_W - 1);

  logic [SW-1:0] r_shift;
  logic [SW-1:0] w_adj;
  logic [CW-1:0] r_cnt;
  logic          r_active;

  // Digits live above the binary field; adjust them before the shift.
  always_comb begin
    w_adj = r_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_shift[BIN_W + 4*d +: 4] >= 4'd5) begin
        w_adj[BIN_W + 4*d +: 4] = r_shift[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_shift  <= {{(4*DIGITS){1'b0}}, bin};
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_shift <= w_adj << 1;
      r_cnt   <= r_cnt + 1'b1;
      if (r_cnt == LAST_CNT) begin
        r_active <= 1'b0;
      end
    end
  end

  assign done = r_active && (r_cnt == LAST_CNT);
  assign bcd  = r_shift[BIN_W +: 4*DIGITS];

endmodule

// File: rtl/bf16_to_dec.sv
// BF16 to signed, rounded-integer packed BCD for the seven-segment driver.
// Optional macro DEC_LEADING_BLANK_EN replaces leading zero digits with the blank code.
module bf16_to_dec
  import bf16_to_dec_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           bf16_in,
  input  logic                  error_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf,
  output logic                  err,
  output logic                  busy,
  output logic                  done,
  output state_t                dbg_state
);

  localparam logic [BIN_W:0]        ONE     = (BIN_W+1)'(1);
  localparam logic [BIN_W:0]        MAX_MAG = (BIN_W+1)'(10**DIGITS - 1);
  localparam logic signed [9:0]     E_MAX   = 10'(BIN_W - 1);

  state_t r_state, w_next;
  res_t   r_kind;

  logic                  r_sign;
  logic                  r_err_in;
  logic [BF16_EXP_W-1:0] r_exp;
  logic [BF16_FRAC_W-1:0] r_frac;
  logic [7:0]            r_mant;
  logic signed [9:0]     r_e;
  logic [BIN_W:0]        r_mag;
  logic                  r_big;

  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_neg;
  logic                  r_ovf;
  logic                  r_err;
  logic                  r_done;

  logic                  w_unpack_err;
  logic                  w_range_ovf;
  logic [BIN_W:0]        w_m_ext;
  logic [BIN_W:0]        w_mag_nxt;
  logic                  w_big_nxt;
  logic [3:0]            w_rnd_sh;
  logic [2:0]            w_half_sh;
  logic [5:0]            w_lsh;
  logic                  w_core_load;
  logic                  w_core_done;
  logic [4*DIGITS-1:0]   w_core_bcd;
  logic [4*DIGITS-1:0]   w_bcd_out;

  assign w_unpack_err = r_err_in || (r_exp == 8'hFF);
  assign w_range_ovf  = r_big || (r_mag > MAX_MAG);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_core_load = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_UNPACK;
      S_UNPACK:  w_next = w_unpack_err ? S_DONE : S_ALIGN;
      S_ALIGN:   w_next = S_RANGE;
      S_RANGE: begin
        if (w_range_ovf) begin
          w_next = S_DONE;
        end else begin
          w_next      = S_CONVERT;
          w_core_load = 1'b1;
        end
      end
      S_CONVERT: if (w_core_done) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Rounded alignment, half away from zero: adding half an LSB before the
  // right shift rounds the magnitude since the sign is handled separately.
  always_comb begin
    w_m_ext   = {{(BIN_W-7){1'b0}}, r_mant};
    w_rnd_sh  = 4'(10'sd7 - r_e);
    w_half_sh = 3'(10'sd6 - r_e);
    w_lsh     = 6'(r_e - 10'sd7);
    w_mag_nxt = '0;
    w_big_nxt = 1'b0;
    if (r_e < -10'sd1) begin
      w_mag_nxt = '0;
    end else if (r_e <= 10'sd6) begin
      w_mag_nxt = (w_m_ext + (ONE << w_half_sh)) >> w_rnd_sh;
    end else if (r_e <= E_MAX) begin
      w_mag_nxt = w_m_ext << w_lsh;
    end else begin
      w_big_nxt = 1'b1;
    end
  end

`ifdef DEC_LEADING_BLANK_EN
  logic w_lead;
  always_comb begin
    w_bcd_out = w_core_bcd;
    w_lead    = 1'b1;
    for (int d = DIGITS-1; d >= 1; d--) begin
      if (w_lead && (w_core_bcd[4*d +: 4] == 4'd0)) begin
        w_bcd_out[4*d +: 4] = BCD_BLANK;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  assign w_bcd_out = w_core_bcd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind   <= RES_NORM;
      r_sign   <= 1'b0;
      r_err_in <= 1'b0;
      r_exp    <= '0;
      r_frac   <= '0;
      r_mant   <= '0;
      r_e      <= '0;
      r_mag    <= '0;
      r_big    <= 1'b0;
      r_bcd    <= '0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign   <= bf16_in[BF16_SIGN_BIT];
            r_exp    <= bf16_in[BF16_EXP_LSB +: BF16_EXP_W];
            r_frac   <= bf16_in[BF16_FRAC_W-1:0];
            r_err_in <= error_in;
          end
        end
        S_UNPACK: begin
          if (w_unpack_err) begin
            r_kind <= RES_ERR;
          end else begin
            r_kind <= RES_NORM;
            // Zero/subnormal: a zero mantissa yields magnitude 0 in every align branch.
            if (r_exp == '0) begin
              r_mant <= '0;
              r_e    <= '0;
            end else begin
              r_mant <= {1'b1, r_frac};
              r_e    <= $signed({2'b00, r_exp}) - 10'(BF16_BIAS);
            end
          end
        end
        S_ALIGN: begin
          r_mag <= w_mag_nxt;
          r_big <= w_big_nxt;
        end
        S_RANGE: begin
          if (w_range_ovf) r_kind <= RES_OVF;
        end
        S_DONE: begin
          r_done <= 1'b1;
          case (r_kind)
            RES_ERR: begin
              r_bcd <= '0;
              r_neg <= 1'b0;
              r_ovf <= 1'b0;
              r_err <= 1'b1;
            end
            RES_OVF: begin
              r_bcd <= '0;
              r_neg <= r_sign;
              r_ovf <= 1'b1;
              r_err <= 1'b0;
            end
            default: begin
              r_bcd <= w_bcd_out;
              r_neg <= r_sign && (r_mag != '0);
              r_ovf <= 1'b0;
              r_err <= 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  bin_to_bcd_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (w_core_load),
    .bin  (r_mag[BIN_W-1:0]),
    .bcd  (w_core_bcd),
    .done (w_core_done)
  );

  assign bcd       = r_bcd;
  assign neg       = r_neg;
  assign ovf       = r_ovf;
  assign err       = r_err;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bf16_to_dec.sv
// Bench for bf16_to_dec: directed vector table, randomized vectors against a
// real-arithmetic reference model, and hand sequences for restart/reset corners.
module tb_bf16_to_dec;
  import bf16_to_dec_pkg::*;

  localparam int DIGITS = 8;
  localparam int BIN_W  = 27;
  localparam int EW     = 4*DIGITS + 3 + 8;  // {bcd, neg, ovf, err, latency}
  localparam int L_NORM = BIN_W + 4;

`ifdef DEC_LEADING_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [15:0]         bf16_in;
  logic                error_in;
  logic [4*DIGITS-1:0] bcd;
  logic                neg, ovf, err, busy, done;
  state_t              dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  logic [EW-1:0] exp_q[$];

  bf16_to_dec #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bf16_in   (bf16_in),
    .error_in  (error_in),
    .bcd       (bcd),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock/reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Decimal digits of an integer, with optional leading blanking.
  function automatic logic [31:0] to_display(input longint mag);
    logic [31:0] r;
    longint m;
    int nd;
    r  = '0;
    m  = mag;
    nd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    m = mag;
    while (m > 0) begin
      nd++;
      m = m / 10;
    end
    if (nd == 0) nd = 1;
    if (BLANK_EN) begin
      for (int i = nd; i < DIGITS; i++) r[4*i +: 4] = BCD_BLANK;
    end
    return r;
  endfunction

  // Reference model: decode to a real value and round half away from zero.
  function automatic logic [EW-1:0] model(input logic [15:0] bf, input logic erri);
    int ex;
    real v, p;
    longint mag;
    logic nb;
    ex = int'(bf[14:7]);
    if (erri || ex == 255) return {32'h0, 1'b0, 1'b0, 1'b1, 8'd2};
    if (ex == 0) begin
      v = 0.0;
    end else begin
      p = 1.0;
      for (int i = 0; i < ex - 127; i++) p = p * 2.0;
      for (int i = 0; i < 127 - ex; i++) p = p / 2.0;
      v = (128.0 + real'(bf[6:0])) / 128.0 * p;
    end
    if (v + 0.5 >= 100000000.0) return {32'h0, bf[15], 1'b1, 1'b0, 8'd4};
    mag = longint'($rtoi(v + 0.5));
    nb  = bf[15] && (mag != 0);
    return {to_display(mag), nb, 1'b0, 1'b0, 8'(L_NORM)};
  endfunction

  // Driver tasks
  task automatic drive_start(input logic [15:0] bf, input logic erri);
    @(negedge clk);
    bf16_in  = bf;
    error_in = erri;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input logic [15:0] bf, input logic erri, input logic [EW-1:0] expv,
                         input string tag);
    int lat;
    logic got;
    logic [EW-1:0] e;
    exp_q.push_back(expv);
    drive_start(bf, erri);
    wait_done(lat, got);
    e = exp_q.pop_front();
    check({tag, " done_seen"}, 64'(got), 64'(1));
    if (got) begin
      check({tag, " bcd"}, 64'(bcd), 64'(e[EW-1 -: 32]));
      check({tag, " neg"}, 64'(neg), 64'(e[10]));
      check({tag, " ovf"}, 64'(ovf), 64'(e[9]));
      check({tag, " err"}, 64'(err), 64'(e[8]));
      check({tag, " latency"}, 64'(lat), 64'(e[7:0]));
    end
  endtask

  typedef struct packed {
    logic [15:0] bf;
    logic        erri;
    logic [31:0] mag;    // plain decimal magnitude, blanking applied later
    logic        neg;
    logic        ovf;
    logic        err;
    logic [7:0]  lat;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [EW-1:0] tbl_exp(input vec_t v);
    logic [31:0] b;
    b = (v.ovf || v.err) ? 32'h0 : to_display(longint'(v.mag));
    return {b, v.neg, v.ovf, v.err, v.lat};
  endfunction

  initial begin
    int k, n_done, first_lat;
    logic [31:0] first_bcd;
    logic [15:0] rb;
    logic re;

    tbl[0]  = '{BF16_ONE, 1'b0, 32'd1,         1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[1]  = '{16'h4A5D, 1'b0, 32'd3620864,   1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[2]  = '{16'hC020, 1'b0, 32'd3,         1'b1, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[3]  = '{16'hBE80, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[4]  = '{16'h4DE4, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 8'd4};
    tbl[5]  = '{BF16_NAN, 1'b0, 32'd0,         1'b0, 1'b0, 1'b1, 8'd2};
    tbl[6]  = '{BF16_ONE, 1'b1, 32'd0,         1'b0, 1'b0, 1'b1, 8'd2};
    tbl[7]  = '{16'h42F6, 1'b0, 32'd123,       1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[8]  = '{BF16_INF, 1'b0, 32'd0,         1'b0, 1'b0, 1'b1, 8'd2};
    tbl[9]  = '{16'h0000, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[10] = '{16'h8000, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[11] = '{16'h3F00, 1'b0, 32'd1,         1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[12] = '{16'h3EFF, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[13] = '{16'h3FC0, 1'b0, 32'd2,         1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[14] = '{16'h4C80, 1'b0, 32'd67108864,  1'b0, 1'b0, 1'b0, 8'(L_NORM)};
    tbl[15] = '{16'h4CFF, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 8'd4};
    tbl[16] = '{16'hCCFF, 1'b0, 32'd0,         1'b1, 1'b1, 1'b0, 8'd4};

    rst = 1'b1; start = 1'b0; bf16_in = '0; error_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset bcd",  64'(bcd),  64'(0));
    check("reset flags", 64'({neg, ovf, err, busy, done}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_vec(tbl[i].bf, tbl[i].erri, tbl_exp(tbl[i]), $sformatf("tbl%0d", i));
    end

    // Outputs hold after done until the next conversion.
    repeat (5) @(posedge clk);
    #1;
    check("hold bcd",  64'(bcd),  64'(tbl_exp(tbl[16]) >> 11));
    check("hold done", 64'(done), 64'(0));

    // Second start during CONVERT is ignored.
    drive_start(BF16_ONE, 1'b0);
    n_done = 0; first_lat = 0; first_bcd = '0;
    for (k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("busy after start", 64'(busy), 64'(1));
      if (k == 10) begin bf16_in = 16'h4A5D; start = 1'b1; end
      if (k == 11) start = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) begin first_lat = k; first_bcd = bcd; end
      end
    end
    check("restart done count", 64'(n_done), 64'(1));
    check("restart latency", 64'(first_lat), 64'(L_NORM));
    check("restart bcd", 64'(first_bcd), 64'(to_display(1)));
    check("restart idle busy", 64'(busy), 64'(0));

    // Reset at E10 aborts the conversion.
    drive_start(16'h4A5D, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort bcd", 64'(bcd), 64'(0));
    check("abort flags", 64'({neg, ovf, err, busy, done}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'(0));
    run_vec(16'hC020, 1'b0, tbl_exp(tbl[2]), "after abort");

    // Randomized vectors against the reference model.
    for (int i = 0; i < 150; i++) begin
      rb[15]   = 1'($urandom_range(0, 1));
      rb[14:7] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(118, 160));
      rb[6:0]  = 7'($urandom_range(0, 127));
      re       = ($urandom_range(0, 15) == 0);
      run_vec(rb, re, model(rb, re), $sformatf("rnd%0d bf=%04h e=%0d", i, rb, re));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bf16_to_dec.md
Name: bf16_to_dec

Overview:
- Downstream display stage for the calculator datapath: consumes the BF16 `result`/`error` pair produced by the ALU ops (factorial, etc.).
- Converts the value to signed, rounded-integer packed BCD for the seven-segment driver.
- Iterative: alignment pipeline followed by a sequential double-dabble converter.
- Single conversion in flight at a time; start/done handshake matching the ALU units.

Parameters:
- DIGITS, 8, number of BCD digits output; max displayable magnitude = 10^DIGITS-1 (99_999_999).
- BIN_W, 27, binary magnitude width fed to double-dabble. Must satisfy 2^BIN_W > 10^DIGITS-1. Sets convert iteration count.

Ports:
- clk  in  1  system clock (300 MHz target)
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- bf16_in  in  16  BF16 operand ({sign, exp[7:0], frac[6:0]}), sampled with start
- error_in  in  1  upstream error flag, sampled with start
- bcd  out  4*DIGITS  packed BCD magnitude, digit 0 in [3:0]
- neg  out  1  displayed value is negative
- ovf  out  1  magnitude exceeds 10^DIGITS-1
- err  out  1  upstream error, NaN or Inf
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; bcd/neg/ovf/err valid and held until next done

Behaviour:
- Reset (synchronous): state=IDLE; bcd=0, neg=0, ovf=0, err=0, done=0, busy=0. Reset asserted mid-conversion aborts the conversion; no done is produced.
- States: IDLE, UNPACK, ALIGN, RANGE, CONVERT, DONE_ST.
- Edge E0, IDLE with start=1: latch bf16_in and error_in; go to UNPACK. start in any other state is ignored.
- UNPACK (E1):
  - If error_in=1 or exp==8'hFF: err result; go to DONE_ST.
  - Else if exp==0 (zero or subnormal, flushed): magnitude 0.
  - Else: m={1,frac} (8 bits), e=exp-127.
  - Go to ALIGN.
- ALIGN (E2), rounded magnitude, round half away from zero:
  - e<-1: 0.
  - -1<=e<=6: (m + (1<<(6-e))) >> (7-e).
  - 7<=e<=BIN_W-1: m << (e-7).
  - e>BIN_W-1: ovf.
  - Intermediate width BIN_W+1.
- RANGE (E3):
  - If ovf or magnitude > 10^DIGITS-1: ovf result; go to DONE_ST.
  - Else load shift register, cnt=0; go to CONVERT.
- CONVERT:
  - One double-dabble iteration per cycle: add 3 to each digit >=5, then shift left 1.
  - Exactly BIN_W iterations (E4..E30 at default); go to DONE_ST.
- DONE_ST (next edge): register outputs, done<=1, go to IDLE. IDLE drives done<=0.
- done timing after E0: normal path at E31 (BIN_W+4); error path at E2; overflow path at E4.
- Output values by result:
  - err result: bcd=0, neg=0, ovf=0, err=1.
  - ovf result: bcd=0, neg=sign, ovf=1, err=0.
  - Normal: neg = sign AND (magnitude != 0). -0.0 and tiny negatives display as 0, neg=0.
- Output registers change only on the done edge (or reset).

Optional Feature:
- Macro: DEC_LEADING_BLANK_EN.
- Defined: leading zero digits above the most significant nonzero digit output as 4'hF (blank code). Digit 0 is never blanked. Applies to bcd on the normal path only.
- Undefined: all digits are plain BCD, including leading zeros.

Decomposition:
- Shared header (define.vh) gains:
  - BF16 field positions/widths, bias 127.
  - BF16 constants: 3F80 one, FFC0 NaN, 7F80 Inf.
  - BCD blank code 4'hF.
  - Default DIGITS/BIN_W.
- One natural sub-module: bin_to_bcd_seq, the sequential double-dabble core.
  - Ports: clk, rst, load, bin[BIN_W-1:0], bcd, done.
  - Parent owns UNPACK/ALIGN/RANGE and output registers.

Test Plan:
- bf16_in=16'h3F80, error_in=0 -> done at E31; bcd=32'h00000001, neg=0, ovf=0, err=0.
- bf16_in=16'h4A5D (10! in BF16 = 3,620,864) -> bcd=32'h03620864, neg=0.
- bf16_in=16'hC020 (-2.5) -> bcd=32'h00000003, neg=1. bf16_in=16'hBE80 (-0.25) -> bcd=0, neg=0.
- bf16_in=16'h4DE4 (12! ≈ 4.79e8) -> done at E4, ovf=1, bcd=0. bf16_in=16'hFFC0 -> done at E2, err=1. error_in=1 with bf16_in=16'h3F80 -> err=1.
- Second start pulsed during CONVERT -> ignored, exactly one done.
- rst at E10 -> outputs 0, no done; new start converts normally.
- With DEC_LEADING_BLANK_EN, bf16_in=16'h42F6 (123.0) -> bcd=32'hFFFFF123. Without the macro -> 32'h00000123.
